wrap_event_logger: RTL

WRAP_EVENT_LOGGER -- requirements
Module: wrap_event_logger

---
 rtl/wrap_event_logger_pkg.sv | 14 +
 rtl/wrap_event_logger_event_fifo.sv | 56 +++++
 rtl/wrap_event_logger.sv | 104 ++++++++++
 3 files changed

// File: rtl/wrap_event_logger_pkg.sv
// Shared definitions for the wrap event logger: parameter defaults and
// the compare FSM state encoding.
package wrap_event_logger_pkg;

  localparam int WRAP_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MATCHED = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/wrap_event_logger_event_fifo.sv
// Small synchronous FIFO holding wrap events; head is visible the cycle after
// the push. A push into a full FIFO is accepted only when a pop happens in the same cycle.
module event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign head_data = r_mem[r_rd_ptr];
  assign w_rd_en   = pop && !empty;
  // When full, the slot being freed by a simultaneous pop is the one written.
  assign w_wr_en   = push && (!full || w_rd_en);

  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wrap_event_logger.sv
// Extends a 4-bit upstream counter with a wrap counter, compares the extended
// count against an armed threshold, and queues wrap events for a consumer.
module wrap_event_logger
  import wrap_event_logger_pkg::*;
#(
  parameter int WRAP_W     = WRAP_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        count_in,
  input  logic              arm,
  input  logic [WRAP_W+3:0] threshold,
  input  logic              evt_ready,
  output logic [WRAP_W+3:0] ext_count,
  output logic              wrap_pulse,
  output logic              match,
  output logic              evt_valid,
  output logic [WRAP_W-1:0] evt_data,
  output logic              dropped,
  output logic              wrap_ovf
);

  logic [3:0]        r_prev_count;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              r_wrap_pulse;
  logic              r_dropped;
  logic              r_wrap_ovf;
  logic [WRAP_W+3:0] r_thresh;
  cmp_state_t        r_state;
  cmp_state_t        w_state_nxt;
  logic              w_match;
  logic              w_wrap;
  logic [WRAP_W-1:0] w_wrap_next;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  assign w_wrap      = (r_prev_count == 4'hF) && (count_in == 4'h0);
  assign w_wrap_next = r_wrap_count + 1'b1;
  assign w_pop       = !w_empty && evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_count <= '0;
      r_wrap_count <= '0;
      r_wrap_pulse <= 1'b0;
      r_dropped    <= 1'b0;
      r_wrap_ovf   <= 1'b0;
    end else begin
      r_prev_count <= count_in;
      r_wrap_pulse <= w_wrap;
      if (w_wrap) begin
        r_wrap_count <= w_wrap_next;
        if (r_wrap_count == '1) r_wrap_ovf <= 1'b1;
        if (w_full && !w_pop) r_dropped <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_thresh <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (arm) r_thresh <= threshold;
    end
  end

  // Arm takes priority over a compare hit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_match     = 1'b0;
    if (arm) begin
      w_state_nxt = ST_ARMED;
    end else if (r_state == ST_ARMED && ext_count == r_thresh) begin
      w_state_nxt = ST_MATCHED;
      w_match     = 1'b1;
    end
  end

  event_fifo #(
    .W     (WRAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_wrap),
    .pop       (w_pop),
    .push_data (w_wrap_next),
    .head_data (evt_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign ext_count  = {r_wrap_count, r_prev_count};
  assign wrap_pulse = r_wrap_pulse;
  assign match      = w_match;
  assign evt_valid  = !w_empty;
  assign dropped    = r_dropped;
  assign wrap_ovf   = r_wrap_ovf;

endmodule
